// File: rtl/alu_word_sequencer.sv
// Multi-cycle wide-operand sequencer in front of a W-bit combinational ALU.
// Define ALU_WORD_SEQ_ERR_EN to reject opcodes 1000-1111 with rsp_err instead of running them.
module alu_word_sequencer #(
    parameter int W      = 32,
    parameter int NWORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [W*NWORDS-1:0]   req_a,
    input  logic [W*NWORDS-1:0]   req_b,
    input  logic                  req_cin,
    output logic [W-1:0]          alu_A,
    output logic [W-1:0]          alu_B,
    output logic [3:0]            alu_sel,
    output logic                  alu_Cin,
    input  logic [W-1:0]          alu_Y,
    input  logic                  alu_Cout,
    input  logic                  alu_Negative,
    input  logic                  alu_Zero,
    input  logic                  alu_Overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [W*NWORDS-1:0]   rsp_y,
    output logic                  rsp_cout,
    output logic                  rsp_neg,
    output logic                  rsp_zero,
    output logic                  rsp_ovf
`ifdef ALU_WORD_SEQ_ERR_EN
    ,
    output logic                  rsp_err
`endif
);

    localparam int WN   = W * NWORDS;
    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    localparam logic [3:0] OP_ADD = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   idx;
    logic [WN-1:0]     a_q;
    logic [WN-1:0]     b_q;
    logic [3:0]        op_q;
    logic              carry;
    logic              zacc;
    logic [WN-1:0]     y_q;
    logic              req_arith;
    logic              req_illegal;
    logic              accept;

    assign req_arith = (req_op == OP_ADD) || (req_op == OP_SUB);

`ifdef ALU_WORD_SEQ_ERR_EN
    assign req_illegal = req_op[3];
`else
    assign req_illegal = 1'b0;
`endif

    assign accept    = (state == IDLE) && req_valid;
    assign rsp_valid = (state == DONE);
    assign rsp_y     = y_q;

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        alu_A      = '0;
        alu_B      = '0;
        alu_sel    = 4'b0000;
        alu_Cin    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_illegal ? DONE : RUN;
                end
            end
            RUN: begin
                alu_A   = a_q[idx*W +: W];
                alu_B   = b_q[idx*W +: W];
                alu_sel = op_q;
                alu_Cin = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? carry : 1'b0;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Nothing may be accepted while reset is being applied.
        if (rst) begin
            req_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 4'b0000;
            carry    <= 1'b0;
            zacc     <= 1'b0;
            y_q      <= '0;
            rsp_cout <= 1'b0;
            rsp_neg  <= 1'b0;
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
`ifdef ALU_WORD_SEQ_ERR_EN
            rsp_err  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                a_q   <= req_a;
                b_q   <= req_b;
                op_q  <= req_op;
                carry <= req_arith ? req_cin : 1'b0;
                zacc  <= 1'b1;
                idx   <= '0;
`ifdef ALU_WORD_SEQ_ERR_EN
                rsp_err <= req_illegal;
                if (req_illegal) begin
                    y_q      <= '0;
                    rsp_cout <= 1'b0;
                    rsp_neg  <= 1'b0;
                    rsp_zero <= 1'b0;
                    rsp_ovf  <= 1'b0;
                end
`endif
            end
            // One word per cycle, carry and zero accumulate into the next pass.
            if (state == RUN) begin
                y_q[idx*W +: W] <= alu_Y;
                carry           <= alu_Cout;
                zacc            <= zacc & alu_Zero;
                if (idx == LAST_IDX) begin
                    rsp_cout <= alu_Cout;
                    rsp_neg  <= alu_Negative;
                    rsp_ovf  <= alu_Overflow;
                    rsp_zero <= zacc & alu_Zero;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed self-checking bench for alu_word_sequencer with a behavioural 32-bit ALU model.
// Define ALU_WORD_SEQ_ERR_EN to also exercise the rsp_err path.
module tb_alu_word_sequencer;

    localparam int W      = 32;
    localparam int NWORDS = 2;
    localparam int WN     = W * NWORDS;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic [WN-1:0]   req_a;
    logic [WN-1:0]   req_b;
    logic            req_cin;
    logic [W-1:0]    alu_A;
    logic [W-1:0]    alu_B;
    logic [3:0]      alu_sel;
    logic            alu_Cin;
    logic [W-1:0]    alu_Y;
    logic            alu_Cout;
    logic            alu_Negative;
    logic            alu_Zero;
    logic            alu_Overflow;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [WN-1:0]   rsp_y;
    logic            rsp_cout;
    logic            rsp_neg;
    logic            rsp_zero;
    logic            rsp_ovf;
`ifdef ALU_WORD_SEQ_ERR_EN
    logic            rsp_err;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_word_sequencer #(.W(W), .NWORDS(NWORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_sel      (alu_sel),
        .alu_Cin      (alu_Cin),
        .alu_Y        (alu_Y),
        .alu_Cout     (alu_Cout),
        .alu_Negative (alu_Negative),
        .alu_Zero     (alu_Zero),
        .alu_Overflow (alu_Overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_cout     (rsp_cout),
        .rsp_neg      (rsp_neg),
        .rsp_zero     (rsp_zero),
        .rsp_ovf      (rsp_ovf)
`ifdef ALU_WORD_SEQ_ERR_EN
        ,
        .rsp_err      (rsp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: SUB is A + ~B + Cin, so Cin=1 means "no borrow in".
    logic [W:0] sum;
    always_comb begin
        sum          = '0;
        alu_Y        = '0;
        alu_Cout     = 1'b0;
        alu_Overflow = 1'b0;
        case (alu_sel)
            4'b0000: alu_Y = alu_A & alu_B;
            4'b0001: alu_Y = alu_A | alu_B;
            4'b0010: alu_Y = ~alu_A;
            4'b0011: alu_Y = ~(alu_A | alu_B);
            4'b0100: alu_Y = alu_A ^ alu_B;
            4'b0101: alu_Y = ~(alu_A & alu_B);
            4'b0110: begin
                sum          = {1'b0, alu_A} + {1'b0, alu_B} + {{W{1'b0}}, alu_Cin};
                alu_Y        = sum[W-1:0];
                alu_Cout     = sum[W];
                alu_Overflow = (alu_A[W-1] == alu_B[W-1]) && (alu_Y[W-1] != alu_A[W-1]);
            end
            4'b0111: begin
                sum          = {1'b0, alu_A} + {1'b0, ~alu_B} + {{W{1'b0}}, alu_Cin};
                alu_Y        = sum[W-1:0];
                alu_Cout     = sum[W];
                alu_Overflow = (alu_A[W-1] != alu_B[W-1]) && (alu_Y[W-1] != alu_A[W-1]);
            end
            default: alu_Y = '0;
        endcase
        alu_Negative = alu_Y[W-1];
        alu_Zero     = (alu_Y == '0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [WN-1:0] a,
                                 input logic [WN-1:0] b, input logic cin);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_valid = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Accept edge plus NWORDS RUN edges, leaving the DUT in DONE.
    task automatic runToDone(input logic [3:0] op, input logic [WN-1:0] a,
                             input logic [WN-1:0] b, input logic cin);
        applyStimulus(op, a, b, cin);
        tick;
        req_valid = 1'b0;
        repeat (NWORDS) tick;
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        checkOutput("handshake_rsp_valid_low", 64'(rsp_valid), 64'd0);
        checkOutput("handshake_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        rsp_ready = 1'b0;

        // Reset state
        tick;
        tick;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_y", rsp_y, 64'd0);
        checkOutput("reset_alu_A", 64'(alu_A), 64'd0);
        checkOutput("reset_alu_sel", 64'(alu_sel), 64'd0);
        checkOutput("reset_rsp_flags", 64'({rsp_cout, rsp_neg, rsp_zero, rsp_ovf}), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);

        // AND with per-cycle observation of the word sequencing
        $display("[TB] AND sequencing");
        applyStimulus(4'b0000, 64'hFFFF0000_F0F0F0F0, 64'h0F0F0F0F_FFFFFFFF, 1'b0);
        tick;
        req_valid = 1'b0;
        checkOutput("and_run0_alu_A", 64'(alu_A), 64'hF0F0F0F0);
        checkOutput("and_run0_alu_B", 64'(alu_B), 64'hFFFFFFFF);
        checkOutput("and_run0_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("and_run0_req_ready", 64'(req_ready), 64'd0);
        tick;
        checkOutput("and_run1_alu_A", 64'(alu_A), 64'hFFFF0000);
        checkOutput("and_run1_rsp_valid", 64'(rsp_valid), 64'd0);
        tick;
        checkOutput("and_done_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("and_rsp_y", rsp_y, 64'h0F0F0000_F0F0F0F0);
        checkOutput("and_rsp_zero", 64'(rsp_zero), 64'd0);
        checkOutput("and_done_alu_A", 64'(alu_A), 64'd0);
`ifdef ALU_WORD_SEQ_ERR_EN
        checkOutput("and_rsp_err", 64'(rsp_err), 64'd0);
`endif
        handshake;

        // ADD with carry chained from the low word into the high word
        $display("[TB] ADD carry chain");
        applyStimulus(4'b0110, 64'h00000000_FFFFFFFF, 64'h00000000_00000001, 1'b0);
        tick;
        req_valid = 1'b0;
        checkOutput("add_run0_alu_Cin", 64'(alu_Cin), 64'd0);
        tick;
        checkOutput("add_run1_alu_Cin", 64'(alu_Cin), 64'd1);
        tick;
        checkOutput("add_rsp_y", rsp_y, 64'h00000001_00000000);
        checkOutput("add_rsp_cout", 64'(rsp_cout), 64'd0);
        checkOutput("add_rsp_zero", 64'(rsp_zero), 64'd0);
        checkOutput("add_rsp_ovf", 64'(rsp_ovf), 64'd0);
        handshake;

        // SUB 0 - 1 with no borrow in: all ones, negative
        $display("[TB] SUB");
        applyStimulus(4'b0111, 64'h0, 64'h1, 1'b1);
        tick;
        req_valid = 1'b0;
        checkOutput("sub_run0_alu_Cin", 64'(alu_Cin), 64'd1);
        tick;
        tick;
        checkOutput("sub_rsp_y", rsp_y, 64'hFFFFFFFF_FFFFFFFF);
        checkOutput("sub_rsp_neg", 64'(rsp_neg), 64'd1);
        checkOutput("sub_rsp_cout", 64'(rsp_cout), 64'd0);
        checkOutput("sub_rsp_ovf", 64'(rsp_ovf), 64'd0);
        handshake;

        // XOR zero-flag accumulation across words
        $display("[TB] XOR zero flag");
        runToDone(4'b0100, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0);
        checkOutput("xor_eq_rsp_y", rsp_y, 64'd0);
        checkOutput("xor_eq_rsp_zero", 64'(rsp_zero), 64'd1);
        checkOutput("xor_eq_rsp_neg", 64'(rsp_neg), 64'd0);
        handshake;
        runToDone(4'b0100, 64'h00000001_00000000, 64'h0, 1'b0);
        checkOutput("xor_hi_rsp_y", rsp_y, 64'h00000001_00000000);
        checkOutput("xor_hi_rsp_zero", 64'(rsp_zero), 64'd0);
        handshake;

        // Backpressure with a competing request held on the input
        $display("[TB] backpressure");
        runToDone(4'b0001, 64'hAAAA5555_0000FFFF, 64'h5555AAAA_00000000, 1'b0);
        applyStimulus(4'b0110, 64'h5, 64'h3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
            checkOutput("bp_rsp_y", rsp_y, 64'hFFFFFFFF_0000FFFF);
            checkOutput("bp_rsp_neg", 64'(rsp_neg), 64'd1);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        checkOutput("bp_release_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("bp_release_req_ready", 64'(req_ready), 64'd1);
        tick;
        req_valid = 1'b0;
        checkOutput("bp_new_alu_A", 64'(alu_A), 64'h5);
        checkOutput("bp_new_req_ready", 64'(req_ready), 64'd0);
        tick;
        tick;
        checkOutput("bp_new_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("bp_new_rsp_y", rsp_y, 64'h8);
        handshake;

        // Reset in the second RUN cycle discards the request
        $display("[TB] reset mid-op");
        applyStimulus(4'b0110, 64'h00000002_00000001, 64'h00000003_00000001, 1'b0);
        tick;
        req_valid = 1'b0;
        tick;
        checkOutput("rst_mid_run1_alu_A", 64'(alu_A), 64'h2);
        rst = 1'b1;
        tick;
        checkOutput("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_mid_alu_A", 64'(alu_A), 64'd0);
        checkOutput("rst_mid_alu_sel", 64'(alu_sel), 64'd0);
        checkOutput("rst_mid_alu_Cin", 64'(alu_Cin), 64'd0);
        checkOutput("rst_mid_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_req_ready_after", 64'(req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick;
            checkOutput("rst_mid_no_response", 64'(rsp_valid), 64'd0);
        end

`ifdef ALU_WORD_SEQ_ERR_EN
        // Illegal opcode bypasses RUN and reports rsp_err
        $display("[TB] illegal opcode");
        applyStimulus(4'b1111, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        #1;
        checkOutput("err_idle_alu_sel", 64'(alu_sel), 64'd0);
        tick;
        req_valid = 1'b0;
        checkOutput("err_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("err_rsp_err", 64'(rsp_err), 64'd1);
        checkOutput("err_rsp_y", rsp_y, 64'd0);
        checkOutput("err_rsp_flags", 64'({rsp_cout, rsp_neg, rsp_zero, rsp_ovf}), 64'd0);
        checkOutput("err_alu_sel", 64'(alu_sel), 64'd0);
        handshake;
        runToDone(4'b0001, 64'h1, 64'h2, 1'b0);
        checkOutput("legal_after_err_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("legal_after_err_rsp_y", rsp_y, 64'h3);
        handshake;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
